// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle between a frame requester and seq_pattern_tx.
// master = requester (drives start/pattern/abort), slave = transmitter.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             use_default;
  logic [WIDTH-1:0] pat_in;
  logic [CNT_W-1:0] reps;
  logic             abort;
  logic             dout;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, use_default, pat_in, reps, abort,
    input  dout, valid, busy, done
  );

  modport slave (
    input  start, use_default, pat_in, reps, abort,
    output dout, valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first, repeated with zero gaps.
// First bit one cycle after the accepted start; no backpressure, abort cancels any frame.
module seq_pattern_tx #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(4'b1010),
  parameter int               GAP         = 1,
  parameter int               CNT_W       = 4
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_tx_if.slave  bus
);

  localparam int BC_W = $clog2(WIDTH) + 1;
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);
  localparam logic [3:0]      GAP_L   = 4'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_d;
  logic [3:0]       gap_cnt, gap_cnt_d;
  logic [WIDTH-1:0] sel_pat;

  assign sel_pat = bus.use_default ? DEFAULT_PAT : bus.pat_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      pat_q   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      pat_q   <= pat_d;
      bit_cnt <= bit_cnt_d;
      rep_cnt <= rep_cnt_d;
      gap_cnt <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt;
    rep_cnt_d = rep_cnt;
    gap_cnt_d = gap_cnt;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          pat_d     = sel_pat;
          shreg_d   = sel_pat;
          rep_cnt_d = (bus.reps == '0) ? CNT_W'(1) : bus.reps;
          bit_cnt_d = BC_FULL;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          shreg_d   = shreg << 1;
          bit_cnt_d = bit_cnt - 1'b1;
          if (bit_cnt == BC_W'(1)) begin
            if (rep_cnt == CNT_W'(1)) begin
              state_d = S_DONE;
            end else begin
              // Reload from the captured copy so pat_in changes never leak in.
              rep_cnt_d = rep_cnt - 1'b1;
              shreg_d   = pat_q;
              bit_cnt_d = BC_FULL;
              if (GAP_L != 4'd0) begin
                gap_cnt_d = GAP_L;
                state_d   = S_GAP;
              end
            end
          end
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt - 1'b1;
          if (gap_cnt == 4'd1) begin
            state_d = S_SEND;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign bus.dout  = (state == S_SEND) && shreg[WIDTH-1];
  assign bus.valid = (state == S_SEND);
  assign bus.busy  = (state == S_SEND) || (state == S_GAP);
  assign bus.done  = (state == S_DONE);

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the sending end of the serial bit-stream interface consumed by the team's Moore sequence detectors. On a start request it shifts a WIDTH-bit pattern out MSB-first on `dout`, one bit per clock, repeats it a programmable number of times with optional zero-filled gaps, then pulses `done`. It sits in front of a detector in loopback benches and drives framed serial test traffic on the board.

## Interface
- WIDTH, 4, pattern length in bits (2..16)
- DEFAULT_PAT, 4'b1010, pattern sent when `use_default`=1
- GAP, 1, idle zero cycles between repetitions (0..15)
- CNT_W, 4, width of repetition count

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  transmission request; sampled only in IDLE
- use_default  in  1  1: send DEFAULT_PAT, 0: send `pat_in`; sampled with `start`
- pat_in  in  WIDTH  pattern, captured on accepted `start`
- reps  in  CNT_W  repetition count, captured on accepted `start`; 0 treated as 1
- abort  in  1  synchronous cancel, effective in any state
- dout  out  1  serial data bit
- valid  out  1  high while `dout` carries a pattern bit
- busy  out  1  high in SEND and GAP
- done  out  1  one-cycle pulse after final bit of final repetition

## Operation
- Moore FSM, registered state; all outputs decoded from state and shift register only (no input-to-output combinational path).
- States: IDLE, SEND, GAP, DONE.
- IDLE: outputs 0. `start`=1 and `abort`=0 -> load shift register with selected pattern, load rep_cnt = (reps==0 ? 1 : reps), bit_cnt = WIDTH; go SEND.
- SEND: `dout` = shreg[WIDTH-1], `valid`=1, `busy`=1. Each cycle shift left (fill 0), bit_cnt−1. On last bit (bit_cnt==1): if rep_cnt==1 -> DONE; else rep_cnt−1, reload pattern and bit_cnt, go GAP if GAP>0 else stay SEND (back-to-back, no bubble).
- GAP: `dout`=0, `valid`=0, `busy`=1 for exactly GAP cycles (gap_cnt), then SEND.
- DONE: `done`=1, other outputs 0, exactly one cycle, then IDLE. `start` in DONE ignored.
- `start`, `pat_in`, `use_default`, `reps` ignored outside IDLE; captured pattern is unaffected by later `pat_in` changes.
- `abort`=1 in SEND/GAP/DONE -> IDLE next edge, no `done` pulse. `abort` and `start` both high in IDLE -> stay IDLE.
- Pattern value is arbitrary (all-zeros legal: `valid`=1, `dout`=0 for WIDTH cycles).

## Timing
- Reset: state IDLE; `dout`, `valid`, `busy`, `done` = 0; shift register, bit_cnt, rep_cnt, gap_cnt = 0. `rst` overrides `abort` and `start`; reset mid-frame truncates the stream on the next edge.
- Latency: `start` sampled at edge N -> first bit (MSB) on `dout` in cycle after edge N; bit k (MSB=0) in cycle N+1+k.
- Frame length in SEND+GAP: R·WIDTH + (R−1)·GAP cycles, R = effective reps; `done` in the following cycle; IDLE one cycle later; earliest next accepted `start` at the edge ending the first IDLE cycle.
- `start` held high continuously -> frames repeat with exactly 2 non-busy cycles (DONE, IDLE) between them.
- Counters never wrap: bit_cnt width clog2(WIDTH)+1, gap_cnt 4 bits, rep_cnt CNT_W bits; reps = 2^CNT_W−1 is the maximum.

## Test plan
- Default pattern: use_default=1, reps=1, GAP=1, start 1 cycle -> `dout` 1,0,1,0 with `valid`=1 on cycles 1–4, `done`=1 cycle 5, all outputs 0 cycle 6.
- Repeats with gap: reps=3, GAP=1 -> `dout` 1010 0 1010 0 1010, `valid` low only in the 2 gap cycles, `busy` high 14 cycles, single `done` pulse.
- Custom pattern, reps=0: use_default=0, pat_in=4'b1101, pat_in changed to 4'b0000 after start -> `dout` 1,1,0,1 (one repetition), `done` once.
- Abort: assert `abort` during the 2nd bit of reps=2 -> next cycle IDLE, `dout`/`valid`/`busy` 0, no `done`; `start` during SEND ignored.
- Reset mid-frame and back-to-back: `rst` during GAP -> all outputs 0 next cycle; `start` held high -> frames separated by exactly 2 idle cycles.
- Loopback: drive the team's Moore 1010 detector with default frame, reps=2, GAP=0 -> detector output asserts once per detected 1010 per its overlap mode.
